// File: rtl/intr_controller_if.sv
// CPU-side bus of the interrupt controller: the intr/inta handshake,
// the acknowledged vector, and the MASK/EOI/SWTRIG register port.
interface intr_controller_if #(
  parameter int N_SRC = 8,
  parameter int VEC_W = 8
);
  logic             intr;
  logic             inta;
  logic [VEC_W-1:0] vector;
  logic             vec_valid;
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [N_SRC-1:0] wr_data;
  logic [1:0]       rd_addr;
  logic [N_SRC-1:0] rd_data;

  modport master (
    input  intr, vector, vec_valid, rd_data,
    output inta, wr_en, wr_addr, wr_data, rd_addr
  );

  modport slave (
    output intr, vector, vec_valid, rd_data,
    input  inta, wr_en, wr_addr, wr_data, rd_addr
  );
endinterface

// File: rtl/intr_controller.sv
// Prioritised, maskable, edge-latched interrupt controller (source 0 highest).
// Define NESTED_INTR_EN to let a higher-priority source pre-empt one in service.
module intr_controller #(
  parameter int               N_SRC    = 8,
  parameter int               VEC_W    = 8,
  parameter logic [VEC_W-1:0] VEC_BASE = VEC_W'(8'h20)
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic [N_SRC-1:0] irq,
  intr_controller_if.slave bus
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] SERV = 2'd2;

`ifdef NESTED_INTR_EN
  localparam bit NESTED = 1'b1;
`else
  localparam bit NESTED = 1'b0;
`endif

  function automatic logic [IW-1:0] low_idx(
    input logic [N_SRC-1:0] v
  );
    low_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (v[i]) low_idx = IW'(i);
  endfunction

  logic [1:0]       state, state_n;
  logic [N_SRC-1:0] mask, pend, inserv, irq_d;
  logic [N_SRC-1:0] pend_n, inserv_n;
  logic [N_SRC-1:0] rise, elig, sw_set, eoi_clr;
  logic [N_SRC-1:0] ack_hot, one;
  logic [IW-1:0]    win, svc_low;
  logic             wr_mask, req_ok, ack;
  logic             intr_q, vv_q;
  logic [VEC_W-1:0] vec_q;

  assign one     = N_SRC'(1);
  assign rise    = irq & ~irq_d;
  assign wr_mask = bus.wr_en && (bus.wr_addr == 2'd0);
  assign eoi_clr = (bus.wr_en && bus.wr_addr == 2'd1)
                   ? bus.wr_data : '0;
  assign sw_set  = (bus.wr_en && bus.wr_addr == 2'd2)
                   ? bus.wr_data : '0;

  assign elig    = pend & ~mask;
  assign win     = low_idx(elig);
  assign svc_low = low_idx(inserv);

  // A request is only worth raising if nothing is in service, or
  // (nested builds) it strictly outranks everything in service.
  assign req_ok = (|elig) &&
                  ((inserv == '0) || (NESTED && (win < svc_low)));

  assign ack     = (state == REQ) && bus.inta && req_ok;
  assign ack_hot = ack ? (one << win) : '0;

  // Set wins over same-cycle ack clear; ack set wins over same-cycle EOI.
  assign pend_n   = (pend & ~ack_hot) | rise | sw_set;
  assign inserv_n = (inserv & ~eoi_clr) | ack_hot;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (req_ok) state_n = REQ;
      REQ: begin
        if (ack)
          state_n = SERV;
        else if (!req_ok)
          state_n = (inserv != '0) ? SERV : IDLE;
      end
      SERV: begin
        if (inserv == '0)
          state_n = IDLE;
        else if (req_ok)
          state_n = REQ;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state  <= IDLE;
      mask   <= '1;
      pend   <= '0;
      inserv <= '0;
      irq_d  <= '0;
      intr_q <= 1'b0;
      vv_q   <= 1'b0;
      vec_q  <= '0;
    end else begin
      state  <= state_n;
      pend   <= pend_n;
      inserv <= inserv_n;
      irq_d  <= irq;
      intr_q <= (state_n == REQ);
      vv_q   <= ack;
      if (wr_mask) mask <= bus.wr_data;
      if (ack) vec_q <= VEC_BASE + VEC_W'(win);
    end
  end

  assign bus.intr      = intr_q;
  assign bus.vec_valid = vv_q;
  assign bus.vector    = vec_q;

  always_comb begin
    bus.rd_data = '0;
    unique case (bus.rd_addr)
      2'd0:    bus.rd_data = mask;
      2'd1:    bus.rd_data = inserv;
      2'd2:    bus.rd_data = pend;
      default: bus.rd_data = '0;
    endcase
  end

endmodule
